// File: rtl/svc_soc_io_pkg.sv
// Shared types and widths for the SOC I/O register bus arbiter.
package svc_soc_io_pkg;

    localparam int IO_ADDR_W = 32;
    localparam int IO_DATA_W = 32;

    typedef struct packed {
        logic                 we;
        logic [IO_ADDR_W-1:0] addr;
        logic [IO_DATA_W-1:0] wdata;
        logic [3:0]           wstrb;
    } io_req_t;

endpackage

// File: rtl/svc_soc_io_skid.sv
// One-entry request register for the debug port: accepts when empty, empties on issue.
module svc_soc_io_skid
    import svc_soc_io_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_valid,
    output logic    in_ready,
    input  io_req_t in_req,
    input  logic    issue,
    output logic    out_valid,
    output io_req_t out_req
);

    logic    valid_q, valid_d;
    io_req_t req_q, req_d;

    // Ready depends only on the flop, so there is no combinational ready-through.
    assign in_ready  = !valid_q;
    assign out_valid = valid_q;
    assign out_req   = req_q;

    always_comb begin
        valid_d = valid_q;
        req_d   = req_q;
        if (issue) begin
            valid_d = 1'b0;
        end
        if (in_valid && !valid_q) begin
            valid_d = 1'b1;
            req_d   = in_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            req_q   <= '0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
        end
    end

endmodule

// File: rtl/svc_soc_io_arb.sv
// Two-master I/O bus arbiter: CPU passes straight through, debug port fills idle channel slots.
module svc_soc_io_arb
    import svc_soc_io_pkg::*;
#(
    parameter int          RD_LATENCY   = 1,
    parameter int unsigned STARVE_LIMIT = 255,
    parameter int          CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_io_ren,
    input  logic [31:0] cpu_io_raddr,
    output logic [31:0] cpu_io_rdata,
    input  logic        cpu_io_wen,
    input  logic [31:0] cpu_io_waddr,
    input  logic [31:0] cpu_io_wdata,
    input  logic [3:0]  cpu_io_wstrb,
    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    input  logic [3:0]  dbg_wstrb,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        dbg_starve,
    output logic        io_ren,
    output logic [31:0] io_raddr,
    input  logic [31:0] io_rdata,
    output logic        io_wen,
    output logic [31:0] io_waddr,
    output logic [31:0] io_wdata,
    output logic [3:0]  io_wstrb
);

    io_req_t            dbg_req;
    io_req_t            pend_req;
    logic               pend_valid;
    logic               wr_issue;
    logic               rd_issue;
    logic               issue;
    logic               rd_owner_q, rd_owner_d;
    logic [CNT_W-1:0]   wait_q, wait_d;

    assign dbg_req = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata, wstrb: dbg_wstrb};

    svc_soc_io_skid u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (dbg_valid),
        .in_ready (dbg_ready),
        .in_req   (dbg_req),
        .issue    (issue),
        .out_valid(pend_valid),
        .out_req  (pend_req)
    );

    // A channel is free only when the CPU leaves its enable low in this cycle.
    assign wr_issue = pend_valid &&  pend_req.we && !cpu_io_wen;
    assign rd_issue = pend_valid && !pend_req.we && !cpu_io_ren;
    assign issue    = wr_issue || rd_issue;

    assign io_wen   = cpu_io_wen || wr_issue;
    assign io_waddr = wr_issue ? pend_req.addr  : cpu_io_waddr;
    assign io_wdata = wr_issue ? pend_req.wdata : cpu_io_wdata;
    assign io_wstrb = wr_issue ? pend_req.wstrb : cpu_io_wstrb;

    assign io_ren   = cpu_io_ren || rd_issue;
    assign io_raddr = rd_issue ? pend_req.addr : cpu_io_raddr;

    assign cpu_io_rdata = io_rdata;

    // Response timing follows the downstream read latency; data is zero outside a response.
    assign dbg_rvalid = (RD_LATENCY == 0) ? rd_issue : rd_owner_q;
    assign dbg_rdata  = dbg_rvalid ? io_rdata : '0;

    assign dbg_starve = 64'(wait_q) > 64'(STARVE_LIMIT);

    always_comb begin
        rd_owner_d = rd_issue;
        wait_d     = wait_q;
        if (issue) begin
            wait_d = '0;
        end else if (pend_valid && (wait_q != {CNT_W{1'b1}})) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner_q <= 1'b0;
            wait_q     <= '0;
        end else begin
            rd_owner_q <= rd_owner_d;
            wait_q     <= wait_d;
        end
    end

endmodule

// File: tb/tb_svc_soc_io_arb.sv
// Directed bench: two arbiter instances (registered and combinational read data) on shared stimulus.
module tb_svc_soc_io_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_io_ren;
    logic [31:0] cpu_io_raddr;
    logic        cpu_io_wen;
    logic [31:0] cpu_io_waddr;
    logic [31:0] cpu_io_wdata;
    logic [3:0]  cpu_io_wstrb;
    logic        dbg_valid;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic [3:0]  dbg_wstrb;
    logic [31:0] io_rdata;

    logic [31:0] cpu_io_rdata_1, cpu_io_rdata_0;
    logic        dbg_ready_1, dbg_ready_0;
    logic        dbg_rvalid_1, dbg_rvalid_0;
    logic [31:0] dbg_rdata_1, dbg_rdata_0;
    logic        dbg_starve_1, dbg_starve_0;
    logic        io_ren_1, io_ren_0;
    logic [31:0] io_raddr_1, io_raddr_0;
    logic        io_wen_1, io_wen_0;
    logic [31:0] io_waddr_1, io_waddr_0;
    logic [31:0] io_wdata_1, io_wdata_0;
    logic [3:0]  io_wstrb_1, io_wstrb_0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    svc_soc_io_arb #(.RD_LATENCY(1), .STARVE_LIMIT(4), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_io_ren(cpu_io_ren), .cpu_io_raddr(cpu_io_raddr), .cpu_io_rdata(cpu_io_rdata_1),
        .cpu_io_wen(cpu_io_wen), .cpu_io_waddr(cpu_io_waddr), .cpu_io_wdata(cpu_io_wdata),
        .cpu_io_wstrb(cpu_io_wstrb),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready_1), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_wstrb(dbg_wstrb),
        .dbg_rvalid(dbg_rvalid_1), .dbg_rdata(dbg_rdata_1), .dbg_starve(dbg_starve_1),
        .io_ren(io_ren_1), .io_raddr(io_raddr_1), .io_rdata(io_rdata),
        .io_wen(io_wen_1), .io_waddr(io_waddr_1), .io_wdata(io_wdata_1), .io_wstrb(io_wstrb_1)
    );

    svc_soc_io_arb #(.RD_LATENCY(0), .STARVE_LIMIT(255), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cpu_io_ren(cpu_io_ren), .cpu_io_raddr(cpu_io_raddr), .cpu_io_rdata(cpu_io_rdata_0),
        .cpu_io_wen(cpu_io_wen), .cpu_io_waddr(cpu_io_waddr), .cpu_io_wdata(cpu_io_wdata),
        .cpu_io_wstrb(cpu_io_wstrb),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready_0), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_wstrb(dbg_wstrb),
        .dbg_rvalid(dbg_rvalid_0), .dbg_rdata(dbg_rdata_0), .dbg_starve(dbg_starve_0),
        .io_ren(io_ren_0), .io_raddr(io_raddr_0), .io_rdata(io_rdata),
        .io_wen(io_wen_0), .io_waddr(io_waddr_0), .io_wdata(io_wdata_0), .io_wstrb(io_wstrb_0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here, checks follow #2 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_send(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        dbg_valid = 1'b1;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = wdata;
        dbg_wstrb = wstrb;
    endtask

    initial begin
        rst_n        = 1'b0;
        cpu_io_ren   = 1'b1;
        cpu_io_raddr = 32'h8000_0000;
        cpu_io_wen   = 1'b0;
        cpu_io_waddr = 32'h0;
        cpu_io_wdata = 32'h0;
        cpu_io_wstrb = 4'h0;
        dbg_valid    = 1'b0;
        dbg_we       = 1'b0;
        dbg_addr     = 32'h0;
        dbg_wdata    = 32'h0;
        dbg_wstrb    = 4'h0;
        io_rdata     = 32'hDEAD_BEEF;

        // Reset values
        #2;
        chk("rst_ready",  {31'b0, dbg_ready_1},  32'd1);
        chk("rst_rvalid", {31'b0, dbg_rvalid_1}, 32'd0);
        chk("rst_rdata",  dbg_rdata_1,           32'd0);
        chk("rst_starve", {31'b0, dbg_starve_1}, 32'd0);
        chk("rst_io_ren", {31'b0, io_ren_1},     32'd1);
        chk("rst_io_wen", {31'b0, io_wen_1},     32'd0);
        chk("rst_rvalid0", {31'b0, dbg_rvalid_0}, 32'd0);
        tick();
        tick();
        rst_n      = 1'b1;
        cpu_io_ren = 1'b0;
        tick();

        // Idle CPU debug write
        dbg_send(1'b1, 32'h8000_0004, 32'h0000_00A5, 4'h1);
        #2;
        chk("w_hs_ready", {31'b0, dbg_ready_1}, 32'd1);
        chk("w_hs_wen",   {31'b0, io_wen_1},    32'd0);
        tick();
        dbg_valid = 1'b0;
        #2;
        chk("w_iss_ready", {31'b0, dbg_ready_1}, 32'd0);
        chk("w_iss_wen",   {31'b0, io_wen_1},    32'd1);
        chk("w_iss_waddr", io_waddr_1,           32'h8000_0004);
        chk("w_iss_wdata", io_wdata_1,           32'h0000_00A5);
        chk("w_iss_wstrb", {28'b0, io_wstrb_1},  32'h1);
        chk("w_iss_ren",   {31'b0, io_ren_1},    32'd0);
        tick();
        #2;
        chk("w_done_ready", {31'b0, dbg_ready_1}, 32'd1);
        chk("w_done_wen",   {31'b0, io_wen_1},    32'd0);
        tick();

        // CPU read collision: CPU reads for 10 cycles while a debug read waits
        cpu_io_ren   = 1'b1;
        cpu_io_raddr = 32'h8000_0000;
        io_rdata     = 32'h1111_0000;
        dbg_send(1'b0, 32'h8000_0008, 32'h0, 4'h0);
        for (int k = 0; k < 10; k++) begin
            #2;
            chk("col_ren",     {31'b0, io_ren_1},     32'd1);
            chk("col_raddr",   io_raddr_1,            32'h8000_0000);
            chk("col_rvalid",  {31'b0, dbg_rvalid_1}, 32'd0);
            chk("col_rvalid0", {31'b0, dbg_rvalid_0}, 32'd0);
            chk("col_cpu_rd",  cpu_io_rdata_1,        32'h1111_0000);
            if (k > 0) chk("col_ready", {31'b0, dbg_ready_1}, 32'd0);
            tick();
            dbg_valid = 1'b0;
        end
        cpu_io_ren = 1'b0;
        io_rdata   = 32'h1234_5678;
        #2;
        chk("col_iss_ren",    {31'b0, io_ren_1},     32'd1);
        chk("col_iss_raddr",  io_raddr_1,            32'h8000_0008);
        chk("col_iss_rvalid", {31'b0, dbg_rvalid_1}, 32'd0);
        chk("lat0_rvalid",    {31'b0, dbg_rvalid_0}, 32'd1);
        chk("lat0_rdata",     dbg_rdata_0,           32'h1234_5678);
        tick();
        cpu_io_ren   = 1'b1;
        cpu_io_raddr = 32'h8000_0040;
        io_rdata     = 32'hCAFE_F00D;
        #2;
        chk("col_rsp_rvalid", {31'b0, dbg_rvalid_1}, 32'd1);
        chk("col_rsp_rdata",  dbg_rdata_1,           32'hCAFE_F00D);
        chk("col_rsp_cpurd",  cpu_io_rdata_1,        32'hCAFE_F00D);
        chk("col_rsp_raddr",  io_raddr_1,            32'h8000_0040);
        chk("col_rsp_ready",  {31'b0, dbg_ready_1},  32'd1);
        chk("lat0_after",     {31'b0, dbg_rvalid_0}, 32'd0);
        tick();
        cpu_io_ren = 1'b0;
        #2;
        chk("col_end_rvalid", {31'b0, dbg_rvalid_1}, 32'd0);
        chk("col_end_rdata",  dbg_rdata_1,           32'd0);
        tick();

        // Channel independence: CPU writes every cycle, debug read issues at once
        cpu_io_wen   = 1'b1;
        cpu_io_waddr = 32'h8000_0010;
        cpu_io_wdata = 32'h0000_0011;
        cpu_io_wstrb = 4'hF;
        dbg_send(1'b0, 32'h8000_000C, 32'h0, 4'h0);
        tick();
        dbg_valid = 1'b0;
        io_rdata  = 32'h0BAD_CAFE;
        #2;
        chk("ind_ren",   {31'b0, io_ren_1}, 32'd1);
        chk("ind_raddr", io_raddr_1,        32'h8000_000C);
        chk("ind_wen",   {31'b0, io_wen_1}, 32'd1);
        chk("ind_waddr", io_waddr_1,        32'h8000_0010);
        chk("ind_wdata", io_wdata_1,        32'h0000_0011);
        tick();
        io_rdata = 32'h5555_AAAA;
        #2;
        chk("ind_rvalid", {31'b0, dbg_rvalid_1}, 32'd1);
        chk("ind_rdata",  dbg_rdata_1,           32'h5555_AAAA);
        tick();

        // Starvation: CPU write held, debug write waits
        dbg_send(1'b1, 32'h8000_0020, 32'h0000_0077, 4'h3);
        tick();
        dbg_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            #2;
            chk("stv_flag",  {31'b0, dbg_starve_1}, (k >= 6) ? 32'd1 : 32'd0);
            chk("stv_waddr", io_waddr_1,            32'h8000_0010);
            chk("stv_flag0", {31'b0, dbg_starve_0}, 32'd0);
            tick();
        end
        cpu_io_wen = 1'b0;
        #2;
        chk("stv_iss_wen",    {31'b0, io_wen_1},     32'd1);
        chk("stv_iss_waddr",  io_waddr_1,            32'h8000_0020);
        chk("stv_iss_wstrb",  {28'b0, io_wstrb_1},   32'h3);
        chk("stv_iss_starve", {31'b0, dbg_starve_1}, 32'd1);
        tick();
        #2;
        chk("stv_clr_starve", {31'b0, dbg_starve_1}, 32'd0);
        chk("stv_clr_wen",    {31'b0, io_wen_1},     32'd0);
        tick();

        // Reset mid-operation with a pending debug read
        cpu_io_ren = 1'b1;
        dbg_send(1'b0, 32'h8000_0030, 32'h0, 4'h0);
        tick();
        dbg_valid = 1'b0;
        #2;
        chk("mid_pend_ready", {31'b0, dbg_ready_1}, 32'd0);
        rst_n      = 1'b0;
        cpu_io_ren = 1'b0;
        #1;
        chk("mid_rst_ready",   {31'b0, dbg_ready_1},  32'd1);
        chk("mid_rst_ren",     {31'b0, io_ren_1},     32'd0);
        chk("mid_rst_rvalid",  {31'b0, dbg_rvalid_1}, 32'd0);
        chk("mid_rst_rvalid0", {31'b0, dbg_rvalid_0}, 32'd0);
        chk("mid_rst_rdata",   dbg_rdata_1,           32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("post_rst_rvalid", {31'b0, dbg_rvalid_1}, 32'd0);
            chk("post_rst_ren",    {31'b0, io_ren_1},     32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
